// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: state encoding and default sizing for the sequential signed multiplier
package seq_mult_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 4;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_SIGN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    LOAD = S_LOAD,
    RUN  = S_RUN,
    SIGN = S_SIGN,
    DONE = S_DONE
  } state_t;
endpackage

// File: rtl/cond_negate.sv
// cond_negate: combinational two's-complement negate when neg is set
module cond_negate #(
  parameter int WIDTH = 16
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  assign out = neg ? -in : in;
endmodule

// File: rtl/seq_signed_mult.sv
// seq_signed_mult: sign-magnitude shift-add multiplier, one bit per cycle.
// Define SEQ_MULT_Q15_EN to add the rounded, saturated q15 output.
module seq_signed_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic               stopled
`ifdef SEQ_MULT_Q15_EN
  ,
  output logic [WIDTH-1:0]   q15
`endif
);
  state_t             state;
  logic [WIDTH-1:0]   ra, rb, ma, mb, mplier;
  logic [2*WIDTH-1:0] mcand, acc, pn;
  logic               sign;
  logic [CNT_W-1:0]   cnt;
  cond_negate #(.WIDTH(WIDTH)) u_neg_a (.neg(ra[WIDTH-1]), .in(ra), .out(ma));
  cond_negate #(.WIDTH(WIDTH)) u_neg_b (.neg(rb[WIDTH-1]), .in(rb), .out(mb));
  cond_negate #(.WIDTH(2*WIDTH)) u_neg_p (.neg(sign), .in(acc), .out(pn));
`ifdef SEQ_MULT_Q15_EN
  logic [WIDTH+1:0] qr;
  logic [WIDTH-1:0] qs;
  // Two guard bits catch both the 0x8000*0x8000 case and rounding carry-out
  assign qr = {pn[2*WIDTH-1], pn[2*WIDTH-1:WIDTH-1]} + {{(WIDTH+1){1'b0}}, pn[WIDTH-2]};
  assign qs = (qr[WIDTH+1:WIDTH-1] == 3'b000 || qr[WIDTH+1:WIDTH-1] == 3'b111) ? qr[WIDTH-1:0] :
              qr[WIDTH+1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ra      <= '0;
      rb      <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      sign    <= 1'b0;
      p       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      stopled <= 1'b0;
`ifdef SEQ_MULT_Q15_EN
      q15     <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          ra      <= a;
          rb      <= b;
          busy    <= 1'b1;
          stopled <= 1'b0;
          state   <= LOAD;
        end
        LOAD: begin
          mcand  <= {{WIDTH{1'b0}}, ma};
          mplier <= mb;
          sign   <= ra[WIDTH-1] ^ rb[WIDTH-1];
          acc    <= '0;
          cnt    <= '0;
          state  <= RUN;
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= SIGN;
        end
        SIGN: begin
          p       <= pn;
`ifdef SEQ_MULT_Q15_EN
          q15     <= qs;
`endif
          done    <= 1'b1;
          stopled <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          // Accepting here lets back-to-back operations issue every 19 cycles
          if (start) begin
            ra      <= a;
            rb      <= b;
            stopled <= 1'b0;
            state   <= LOAD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_signed_mult.sv
// tb_seq_signed_mult: vector table plus corner sequences, scoreboard checks each done pulse
module tb_seq_signed_mult;
  localparam int W = 16;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, stopled;
  logic [2*W-1:0] p, exp_p;
`ifdef SEQ_MULT_Q15_EN
  logic [W-1:0] q15;
`endif
  int tests = 0, fails = 0, dones = 0;
  logic [2*W-1:0] sb[$];
  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;
  vec_t vecs[10];

  seq_signed_mult #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .p(p), .stopled(stopled)
`ifdef SEQ_MULT_Q15_EN
    , .q15(q15)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

`ifdef SEQ_MULT_Q15_EN
  function automatic logic [W-1:0] q15_ref(input logic [2*W-1:0] pv);
    int v;
    v = int'($signed(pv[2*W-1:W-1])) + int'(pv[W-2]);
    return v > 32767 ? 16'h7FFF : v < -32768 ? 16'h8000 : W'(v);
  endfunction
`endif

  always @(negedge clk) if (done) begin
    dones++;
    if (sb.size() == 0) chk("unexpected_done", 1, 0);
    else begin
      exp_p = sb.pop_front();
      chk("p", p, exp_p);
      chk("stopled_with_done", stopled, 1);
`ifdef SEQ_MULT_Q15_EN
      chk("q15", q15, q15_ref(exp_p));
`endif
    end
  end

  task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2*W-1:0] e, input bit push);
    a = ia;
    b = ib;
    start = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_one(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2*W-1:0] e);
    int lat;
    launch(ia, ib, e, 1'b1);
    chk("busy_after_start", busy, 1);
    wait_done(lat);
    chk("latency", lat, 18);
    @(posedge clk);
    #1;
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int lat, d0, pr;
    logic [W-1:0] ra, rb;
    vecs = '{
      '{16'h0003, 16'h0005, 32'h0000000F},
      '{16'hFFFD, 16'h0005, 32'hFFFFFFF1},
      '{16'h8000, 16'h8000, 32'h40000000},
      '{16'h8000, 16'h7FFF, 32'hC0008000},
      '{16'h0000, 16'h1234, 32'h00000000},
      '{16'hFFFF, 16'hFFFF, 32'h00000001},
      '{16'h7FFF, 16'h7FFF, 32'h3FFF0001},
      '{16'h8000, 16'h0001, 32'hFFFF8000},
      '{16'h1234, 16'hFFFF, 32'hFFFFEDCC},
      '{16'h7FFF, 16'h8000, 32'hC0008000}
    };
    #1;
    chk("rst_p", p, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stopled", stopled, 0);
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 10; i++) run_one(vecs[i].a, vecs[i].b, vecs[i].p);
    repeat (6) begin
      ra = W'($urandom);
      rb = W'($urandom);
      pr = int'($signed(ra)) * int'($signed(rb));
      run_one(ra, rb, 32'(pr));
    end
    // start re-pulsed during RUN with new operands must be ignored
    d0 = dones;
    launch(16'd7, 16'd9, 32'd63, 1'b1);
    repeat (4) @(posedge clk);
    #1 a = 16'd100;
    b = 16'd100;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = 16'hFFFF;
    b = 16'h0001;
    wait_done(lat);
    chk("restart_latency", lat, 13);
    repeat (25) @(posedge clk);
    #1 chk("restart_single_done", dones, d0 + 1);
    // reset asserted before edge k+10 aborts the operation
    d0 = dones;
    launch(16'h1234, 16'h0010, '0, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_p", p, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_stopled", stopled, 0);
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("abort_no_done", dones, d0);
    chk("abort_p_hold", p, 0);
    chk("abort_idle", busy, 0);
    run_one(16'h0011, 16'h0011, 32'h00000121);
    // back-to-back: second start sampled on the edge leaving DONE
    launch(16'hFF00, 16'h0100, 32'hFFFF0000, 1'b1);
    wait_done(lat);
    chk("b2b_first_latency", lat, 18);
    launch(16'h0123, 16'hFEDC, 32'(int'($signed(16'h0123)) * int'($signed(16'hFEDC))), 1'b1);
    chk("b2b_busy", busy, 1);
    chk("b2b_stopled_clear", stopled, 0);
    chk("b2b_done_low", done, 0);
    wait_done(lat);
    chk("b2b_second_latency", lat, 18);
    @(posedge clk);
    #1 chk("b2b_idle", busy, 0);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
